mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port arbiter between the instruction cache, the data cache and the shared memory interface. It forwards one request per cycle to memory. The dcache has priority by default, with a starvation guard for the icache. Each accepted load is recorded in a tag-owner table, so later memory data responses are routed back to the cache that issued them. It sits directly downstream of `dcache` and `icache` and directly upstream of memory.

## Interface
- `STARVE_LIMIT`, default 4: consecutive icache-blocked cycles after which the icache gets priority.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `dcache_command` in `MEM_COMMAND`: dcache request (`MEM_NONE`/`MEM_LOAD`/`MEM_STORE`).
- `dcache_addr` in `ADDR`: dcache block address.
- `dcache_data` in `MEM_BLOCK`: dcache store data.
- `icache_command` in `MEM_COMMAND`: icache request (`MEM_NONE`/`MEM_LOAD` only).
- `icache_addr` in `ADDR`: icache block address.
- `mem2proc_transaction_tag` in `MEM_TAG`: memory accept tag for this cycle's command; 0 means rejected.
- `mem2proc_data` in `MEM_BLOCK`: returned load data.
- `mem2proc_data_tag` in `MEM_TAG`: tag of returned data; 0 means none.
- `proc2mem_command` out `MEM_COMMAND`: forwarded command.
- `proc2mem_addr` out `ADDR`: forwarded address.
- `proc2mem_data` out `MEM_BLOCK`: forwarded store data.
- `Dmem2proc_transaction_tag` out `MEM_TAG`: accept tag to dcache.
- `Dmem2proc_data` out `MEM_BLOCK`: data to dcache.
- `Dmem2proc_data_tag` out `MEM_TAG`: data tag to dcache.
- `Imem2proc_transaction_tag` out `MEM_TAG`: accept tag to icache.
- `Imem2proc_data` out `MEM_BLOCK`: data to icache.
- `Imem2proc_data_tag` out `MEM_TAG`: data tag to icache.
- `protocol_error` out 1: sticky; set on a data response whose tag has no owner.

## Operation
- **Grant (combinational).**
  - The dcache wins whenever `dcache_command != MEM_NONE`, unless `starve_cnt == STARVE_LIMIT` and the icache is requesting; then the icache wins.
  - The winner's command, address and data drive `proc2mem_*`.
  - With no request: `MEM_NONE`, address 0, data 0.
- **Accept routing.**
  - `mem2proc_transaction_tag` goes to the winner's `*_transaction_tag`.
  - The loser always sees 0 and must retry next cycle.
- **Owner table.** `NUM_MEM_TAGS` entries indexed by tag (index 0 unused), each holding valid plus owner (`OWNER_I`/`OWNER_D`).
  - At posedge, an accepted `MEM_LOAD` (tag != 0) sets entry[tag] = {1, winner}.
  - Accepted stores allocate nothing; memory returns no data for stores.
- **Data routing.**
  - If `mem2proc_data_tag != 0` and entry[tag] is valid, drive data and tag to that owner's `*mem2proc_data*`; the other side sees tag 0.
  - At posedge, clear entry[tag].
  - If the entry is invalid: drop the response (both sides see tag 0) and set `protocol_error`.
- **Same tag freed and allocated in one cycle:** routing uses the old owner; the new allocation wins in the next table state.
- **Starvation counter** `starve_cnt`, range 0..`STARVE_LIMIT`:
  - Increments when the icache requests and is not accepted, saturating at `STARVE_LIMIT`.
  - Clears when the icache is accepted or the icache command is `MEM_NONE`.
  - When the icache wins but memory rejects, the counter holds at `STARVE_LIMIT`.
- **Reset.** Clears the table, `starve_cnt` and `protocol_error`. Responses arriving after a mid-operation reset hit invalid entries and are dropped, setting the error flag.

## Timing
- Request, grant and accept tag are all combinational within one cycle. Data routing is combinational from `mem2proc_data_tag` to the per-cache outputs.
- Table and counter update at posedge. An allocation is visible to data routing from the next cycle.
- Reset values: every tag output is 0, `proc2mem_command = MEM_NONE`, and all data and address outputs are 0 while no request is present. `protocol_error = 0`.
- No added latency on either path.

## Structure
- `OWNER_T` enum (`OWNER_I`, `OWNER_D`) and the `MEM_OWNER_ENTRY` struct belong in `sys_defs.svh`, alongside `MEM_TAG`, `MEM_BLOCK`, `MEM_COMMAND` and `NUM_MEM_TAGS`.
- One sub-module: `mem_tag_table` (owner table with allocate/lookup/free ports).
- Grant logic and the starvation counter live in the top module.

## Test plan
- **dcache load only:** `dcache_addr = 0x100`, memory tag 3 → `Dmem2proc_transaction_tag = 3`, `Imem2proc_transaction_tag = 0`. Later `data_tag = 3` with data `0xDEAD` → appears on `Dmem2proc_data`; entry 3 cleared.
- **Simultaneous requests:** icache 0x200, dcache 0x300 → `proc2mem_addr = 0x300`, icache tag 0.
- **Starvation:** continuous dcache and icache requests, `STARVE_LIMIT = 4` → icache granted in the 5th cycle, then the counter clears.
- **dcache store:** accepted with tag 5 → no entry allocated. A `data_tag = 5` response then sets `protocol_error = 1` and both data tags read 0.
- **Same-cycle free/alloc:** icache load holds tag 2; in one cycle memory returns data tag 2 while accepting a dcache load with tag 2 → data goes to the icache. The next data tag 2 goes to the dcache.
- **Reset mid-flight:** outstanding tag 7, reset asserted → all outputs go to reset values. A later `data_tag = 7` is dropped and the error flag is set.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface types for the cache/memory arbiter: commands,
// tags, blocks and the tag-owner table entry.
package mem_arbiter_pkg;

    localparam int NUM_MEM_TAGS = 16;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } OWNER_T;

    typedef struct packed {
        logic   valid;
        OWNER_T owner;
    } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_arbiter_tag_table.sv
// Tag-owner table: records which cache issued each outstanding load so that
// returning data can be routed back to it.
module mem_tag_table
    import mem_arbiter_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           i_alloc_en,
    input  MEM_TAG         i_alloc_tag,
    input  OWNER_T         i_alloc_owner,
    input  MEM_TAG         i_lookup_tag,
    output MEM_OWNER_ENTRY o_lookup,
    input  logic           i_free_en,
    input  MEM_TAG         i_free_tag
);

    MEM_OWNER_ENTRY r_table [NUM_MEM_TAGS];

    // NOTE: only the valid bits are reset; owner bits are meaningless while
    // invalid, so leaving them unreset keeps the array a plain register file.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NUM_MEM_TAGS; t++) begin
                r_table[t].valid <= 1'b0;
            end
        end else begin
            // NOTE: with non-blocking assignments the later statement wins, so
            // a same-cycle free and allocate of one tag leaves it allocated.
            if (i_free_en) begin
                r_table[i_free_tag].valid <= 1'b0;
            end
            if (i_alloc_en) begin
                r_table[i_alloc_tag] <= '{valid: 1'b1, owner: i_alloc_owner};
            end
        end
    end

    assign o_lookup = r_table[i_lookup_tag];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between icache and dcache: dcache priority with
// an icache starvation guard, and tag-based routing of returned load data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  MEM_COMMAND dcache_command,
    input  ADDR        dcache_addr,
    input  MEM_BLOCK   dcache_data,
    input  MEM_COMMAND icache_command,
    input  ADDR        icache_addr,
    input  MEM_TAG     mem2proc_transaction_tag,
    input  MEM_BLOCK   mem2proc_data,
    input  MEM_TAG     mem2proc_data_tag,
    output MEM_COMMAND proc2mem_command,
    output ADDR        proc2mem_addr,
    output MEM_BLOCK   proc2mem_data,
    output MEM_TAG     Dmem2proc_transaction_tag,
    output MEM_BLOCK   Dmem2proc_data,
    output MEM_TAG     Dmem2proc_data_tag,
    output MEM_TAG     Imem2proc_transaction_tag,
    output MEM_BLOCK   Imem2proc_data,
    output MEM_TAG     Imem2proc_data_tag,
    output logic       protocol_error
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_protocol_error;

    logic           w_i_req;
    logic           w_d_req;
    logic           w_i_win;
    logic           w_d_win;
    logic           w_mem_accept;
    logic           w_alloc_en;
    logic           w_resp_present;
    logic           w_resp_hit;
    MEM_OWNER_ENTRY w_resp_entry;

    assign w_i_req      = (icache_command != MEM_NONE);
    assign w_d_req      = (dcache_command != MEM_NONE);
    assign w_i_win      = w_i_req && (!w_d_req || (r_starve_cnt == CNT_W'(STARVE_LIMIT)));
    assign w_d_win      = w_d_req && !w_i_win;
    assign w_mem_accept = (mem2proc_transaction_tag != '0);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        proc2mem_command          = MEM_NONE;
        proc2mem_addr             = '0;
        proc2mem_data             = '0;
        Imem2proc_transaction_tag = '0;
        Dmem2proc_transaction_tag = '0;
        if (w_i_win) begin
            proc2mem_command          = icache_command;
            proc2mem_addr             = icache_addr;
            Imem2proc_transaction_tag = mem2proc_transaction_tag;
        end else if (w_d_win) begin
            proc2mem_command          = dcache_command;
            proc2mem_addr             = dcache_addr;
            proc2mem_data             = dcache_data;
            Dmem2proc_transaction_tag = mem2proc_transaction_tag;
        end
    end

    // Stores never return data, so only accepted loads claim a tag.
    assign w_alloc_en = (proc2mem_command == MEM_LOAD) && w_mem_accept;

    mem_tag_table u_tag_table (
        .clock         (clock),
        .reset         (reset),
        .i_alloc_en    (w_alloc_en),
        .i_alloc_tag   (mem2proc_transaction_tag),
        .i_alloc_owner (w_i_win ? OWNER_I : OWNER_D),
        .i_lookup_tag  (mem2proc_data_tag),
        .o_lookup      (w_resp_entry),
        .i_free_en     (w_resp_hit),
        .i_free_tag    (mem2proc_data_tag)
    );

    assign w_resp_present = (mem2proc_data_tag != '0);
    assign w_resp_hit     = w_resp_present && w_resp_entry.valid;

    always_comb begin
        Imem2proc_data_tag = '0;
        Imem2proc_data     = '0;
        Dmem2proc_data_tag = '0;
        Dmem2proc_data     = '0;
        if (w_resp_hit && (w_resp_entry.owner == OWNER_I)) begin
            Imem2proc_data_tag = mem2proc_data_tag;
            Imem2proc_data     = mem2proc_data;
        end else if (w_resp_hit) begin
            Dmem2proc_data_tag = mem2proc_data_tag;
            Dmem2proc_data     = mem2proc_data;
        end
    end

    // A rejected icache grant at the limit holds the count, keeping priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt     <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            if (!w_i_req || (w_i_win && w_mem_accept)) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
            if (w_resp_present && !w_resp_entry.valid) begin
                r_protocol_error <= 1'b1;
            end
        end
    end

    assign protocol_error = r_protocol_error;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, compared every cycle against a behavioural reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic       clock = 1'b0;
    logic       reset;
    MEM_COMMAND dcache_command, icache_command;
    ADDR        dcache_addr, icache_addr;
    MEM_BLOCK   dcache_data, mem2proc_data;
    MEM_TAG     mem2proc_transaction_tag, mem2proc_data_tag;
    MEM_COMMAND proc2mem_command;
    ADDR        proc2mem_addr;
    MEM_BLOCK   proc2mem_data;
    MEM_TAG     Dmem2proc_transaction_tag, Dmem2proc_data_tag;
    MEM_TAG     Imem2proc_transaction_tag, Imem2proc_data_tag;
    MEM_BLOCK   Dmem2proc_data, Imem2proc_data;
    logic       protocol_error;

    int checks = 0;
    int errors = 0;

    // Reference model: owner per tag (0 = free, 1 = icache, 2 = dcache).
    int m_owner [NUM_MEM_TAGS];
    int m_starve;
    bit m_perr;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .dcache_command            (dcache_command),
        .dcache_addr               (dcache_addr),
        .dcache_data               (dcache_data),
        .icache_command            (icache_command),
        .icache_addr               (icache_addr),
        .mem2proc_transaction_tag  (mem2proc_transaction_tag),
        .mem2proc_data             (mem2proc_data),
        .mem2proc_data_tag         (mem2proc_data_tag),
        .proc2mem_command          (proc2mem_command),
        .proc2mem_addr             (proc2mem_addr),
        .proc2mem_data             (proc2mem_data),
        .Dmem2proc_transaction_tag (Dmem2proc_transaction_tag),
        .Dmem2proc_data            (Dmem2proc_data),
        .Dmem2proc_data_tag        (Dmem2proc_data_tag),
        .Imem2proc_transaction_tag (Imem2proc_transaction_tag),
        .Imem2proc_data            (Imem2proc_data),
        .Imem2proc_data_tag        (Imem2proc_data_tag),
        .protocol_error            (protocol_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = no request, 1 = icache granted, 2 = dcache granted
    function automatic int winner();
        bit ir;
        bit dr;
        ir = (icache_command != MEM_NONE);
        dr = (dcache_command != MEM_NONE);
        if (ir && (!dr || m_starve == LIMIT)) return 1;
        if (dr) return 2;
        return 0;
    endfunction

    task automatic check_model();
        int w;
        int own;
        MEM_COMMAND ecmd;
        w    = winner();
        own  = (mem2proc_data_tag != 0) ? m_owner[mem2proc_data_tag] : 0;
        ecmd = (w == 1) ? icache_command : (w == 2) ? dcache_command : MEM_NONE;
        check("cmd",   proc2mem_command, ecmd);
        check("addr",  proc2mem_addr, (w == 1) ? icache_addr : (w == 2) ? dcache_addr : 32'h0);
        check("wdata", proc2mem_data, (w == 2) ? dcache_data : 64'h0);
        check("d_ttag", Dmem2proc_transaction_tag, (w == 2) ? mem2proc_transaction_tag : 4'h0);
        check("i_ttag", Imem2proc_transaction_tag, (w == 1) ? mem2proc_transaction_tag : 4'h0);
        check("d_dtag", Dmem2proc_data_tag, (own == 2) ? mem2proc_data_tag : 4'h0);
        check("i_dtag", Imem2proc_data_tag, (own == 1) ? mem2proc_data_tag : 4'h0);
        check("d_data", Dmem2proc_data, (own == 2) ? mem2proc_data : 64'h0);
        check("i_data", Imem2proc_data, (own == 1) ? mem2proc_data : 64'h0);
        check("perr",  protocol_error, m_perr);
    endtask

    // Inputs change 1 ns after a posedge; outputs are sampled at the negedge.
    task automatic drive(input MEM_COMMAND dc, input ADDR da, input MEM_BLOCK dd,
                         input MEM_COMMAND ic, input ADDR ia, input MEM_TAG mt,
                         input MEM_BLOCK md, input MEM_TAG mdt);
        dcache_command = dc; dcache_addr = da; dcache_data = dd;
        icache_command = ic; icache_addr = ia;
        mem2proc_transaction_tag = mt; mem2proc_data = md; mem2proc_data_tag = mdt;
        #4;
    endtask

    task automatic idle();
        drive(MEM_NONE, 0, 0, MEM_NONE, 0, 0, 0, 0);
    endtask

    task automatic tick();
        int w;
        MEM_COMMAND wcmd;
        w    = winner();
        wcmd = (w == 1) ? icache_command : dcache_command;
        @(posedge clock);
        if (reset) begin
            foreach (m_owner[t]) m_owner[t] = 0;
            m_starve = 0;
            m_perr   = 1'b0;
        end else begin
            if (mem2proc_data_tag != 0) begin
                if (m_owner[mem2proc_data_tag] != 0) m_owner[mem2proc_data_tag] = 0;
                else m_perr = 1'b1;
            end
            if (w != 0 && mem2proc_transaction_tag != 0 && wcmd == MEM_LOAD)
                m_owner[mem2proc_transaction_tag] = w;
            if (icache_command == MEM_NONE) m_starve = 0;
            else if (w == 1 && mem2proc_transaction_tag != 0) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
        end
        #1;
    endtask

    initial begin
        int q[$];
        foreach (m_owner[t]) m_owner[t] = 0;
        m_starve = 0;
        m_perr   = 1'b0;

        // Reset state
        reset = 1'b1;
        idle(); tick();
        idle(); check_model(); tick();
        reset = 1'b0;
        idle(); check_model();
        check("rst_perr", protocol_error, 1'b0);
        tick();

        // dcache load alone, then its data returns
        drive(MEM_LOAD, 32'h100, 0, MEM_NONE, 0, 4'd3, 0, 0);
        check_model();
        check("t1_d_ttag", Dmem2proc_transaction_tag, 4'd3);
        check("t1_i_ttag", Imem2proc_transaction_tag, 4'd0);
        tick();
        idle(); check_model(); tick();
        drive(MEM_NONE, 0, 0, MEM_NONE, 0, 0, 64'hDEAD, 4'd3);
        check_model();
        check("t1_d_data", Dmem2proc_data, 64'hDEAD);
        check("t1_d_dtag", Dmem2proc_data_tag, 4'd3);
        tick();

        // Simultaneous requests: dcache wins, icache sees tag 0
        drive(MEM_LOAD, 32'h300, 0, MEM_LOAD, 32'h200, 4'd1, 0, 0);
        check_model();
        check("t2_addr", proc2mem_addr, 32'h300);
        check("t2_i_ttag", Imem2proc_transaction_tag, 4'd0);
        tick();
        idle(); check_model(); tick();

        // Same-cycle free and reallocation of tag 2
        drive(MEM_NONE, 0, 0, MEM_LOAD, 32'h240, 4'd2, 0, 0);
        check_model(); tick();
        drive(MEM_LOAD, 32'h340, 0, MEM_NONE, 0, 4'd2, 64'hCAFE, 4'd2);
        check_model();
        check("t3_i_data", Imem2proc_data, 64'hCAFE);
        check("t3_d_dtag", Dmem2proc_data_tag, 4'd0);
        tick();
        drive(MEM_NONE, 0, 0, MEM_NONE, 0, 0, 64'hBEEF, 4'd2);
        check_model();
        check("t3_d_data", Dmem2proc_data, 64'hBEEF);
        check("t3_i_dtag", Imem2proc_data_tag, 4'd0);
        tick();

        // Starvation: icache granted on the 5th contended cycle, then cleared
        for (int i = 0; i < 6; i++) begin
            drive(MEM_LOAD, 32'h400, 0, MEM_LOAD, 32'h500, MEM_TAG'(8 + i), 0, 0);
            check_model();
            check("t4_addr", proc2mem_addr, (i == 4) ? 32'h500 : 32'h400);
            check("t4_i_ttag", Imem2proc_transaction_tag, (i == 4) ? 4'(8 + i) : 4'd0);
            tick();
        end
        idle(); check_model(); tick();

        // Store allocates nothing; a response on its tag is a protocol error
        drive(MEM_STORE, 32'h600, 64'h1234, MEM_NONE, 0, 4'd5, 0, 0);
        check_model();
        check("t5_data", proc2mem_data, 64'h1234);
        tick();
        drive(MEM_NONE, 0, 0, MEM_NONE, 0, 0, 64'h77, 4'd5);
        check_model();
        check("t5_d_dtag", Dmem2proc_data_tag, 4'd0);
        check("t5_i_dtag", Imem2proc_data_tag, 4'd0);
        tick();
        idle(); check_model();
        check("t5_perr", protocol_error, 1'b1);
        tick();

        // Reset with tag 7 outstanding; its late response is dropped
        drive(MEM_LOAD, 32'h700, 0, MEM_NONE, 0, 4'd7, 0, 0);
        check_model(); tick();
        reset = 1'b1;
        idle(); tick();
        idle(); check_model();
        check("t6_perr_rst", protocol_error, 1'b0);
        check("t6_cmd_rst", proc2mem_command, MEM_NONE);
        tick();
        reset = 1'b0;
        drive(MEM_NONE, 0, 0, MEM_NONE, 0, 0, 64'hAA, 4'd7);
        check_model();
        check("t6_d_dtag", Dmem2proc_data_tag, 4'd0);
        tick();
        idle(); check_model();
        check("t6_perr", protocol_error, 1'b1);
        tick();

        // Random traffic from a clean state
        reset = 1'b1;
        idle(); tick();
        reset = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            MEM_COMMAND dc;
            MEM_COMMAND ic;
            MEM_TAG     mt;
            MEM_TAG     mdt;
            case ($urandom_range(3, 0))
                0:       dc = MEM_NONE;
                1:       dc = MEM_STORE;
                default: dc = MEM_LOAD;
            endcase
            ic  = ($urandom_range(2, 0) == 0) ? MEM_NONE : MEM_LOAD;
            mt  = ($urandom_range(3, 0) == 0) ? 4'd0 : MEM_TAG'($urandom_range(15, 1));
            mdt = 4'd0;
            q.delete();
            for (int t = 1; t < NUM_MEM_TAGS; t++) if (m_owner[t] != 0) q.push_back(t);
            if (q.size() > 0 && $urandom_range(1, 0) == 1)
                mdt = MEM_TAG'(q[$urandom_range(q.size() - 1, 0)]);
            drive(dc, ADDR'($urandom), {$urandom, $urandom}, ic, ADDR'($urandom), mt,
                  {$urandom, $urandom}, mdt);
            check_model();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
